// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_transmitter #(
    parameter int unsigned CLK_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       ok,
    output logic       busy,
    output logic       txd
);

    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
`ifdef UART_TX_PARITY_EN
    logic             parity;
`endif

    logic bit_end;
    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= StIdle;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            busy   <= 1'b0;
            txd    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity <= 1'b0;
`endif
        end else if (state == StIdle) begin
            // txd drops on the accepting edge itself, so the start bit has zero latency
            if (ok) begin
                shreg  <= data;
                state  <= StStart;
                busy   <= 1'b1;
                txd    <= 1'b0;
                cnt    <= '0;
                idx    <= '0;
`ifdef UART_TX_PARITY_EN
                parity <= ^data;
`endif
            end
        end else begin
            cnt <= bit_end ? '0 : cnt + CNT_W'(1);
            if (bit_end) begin
                case (state)
                    StStart: begin
                        state <= StData;
                        txd   <= shreg[0];
                        shreg <= shreg >> 1;
                        idx   <= '0;
                    end
                    StData: begin
                        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= StParity;
                            txd   <= parity;
`else
                            state <= StStop;
                            txd   <= 1'b1;
`endif
                        end else begin
                            idx   <= idx + 3'd1;
                            txd   <= shreg[0];
                            shreg <= shreg >> 1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    StParity: begin
                        state <= StStop;
                        txd   <= 1'b1;
                    end
`endif
                    StStop: begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        txd   <= 1'b1;
                    end
                    default: begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        txd   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter with CLK_PER_BIT=4; a negedge monitor
// checks every line cycle of each frame against the queued expected frame.
module tb_uart_transmitter;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FW = 11;
`else
    localparam int unsigned FW = 10;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] data;
    logic       ok;
    logic       busy;
    logic       txd;

    uart_transmitter #(.CLK_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .ok    (ok),
        .busy  (busy),
        .txd   (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [FW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [FW-1:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    // Monitor: frame bit i is expected on every cycle i*CPB .. i*CPB+CPB-1 of busy.
    logic          mon_active = 1'b0;
    logic          have_exp   = 1'b0;
    logic [FW-1:0] cur_exp    = '0;
    int            mon_cyc    = 0;
    int            idle_cnt   = 0;
    int            last_gap   = 0;
    int            frames_done = 0;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_txd", {31'b0, txd}, 32'd1);
            check("rst_busy", {31'b0, busy}, 32'd0);
            if (mon_active && have_exp) exp_q.delete(0);
            mon_active = 1'b0;
            idle_cnt   = 0;
        end else if (!mon_active) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    cur_exp  = '1;
                    have_exp = 1'b0;
                end else begin
                    cur_exp  = exp_q[0];
                    have_exp = 1'b1;
                end
                mon_active = 1'b1;
                last_gap   = idle_cnt;
                idle_cnt   = 0;
                check("txd_bit", {31'b0, txd}, {31'b0, cur_exp[0]});
                mon_cyc = 1;
            end else begin
                check("idle_txd", {31'b0, txd}, 32'd1);
                idle_cnt++;
            end
        end else if (busy) begin
            if (mon_cyc < int'(FW * CPB))
                check("txd_bit", {31'b0, txd}, {31'b0, cur_exp[mon_cyc / CPB]});
            mon_cyc++;
        end else begin
            check("busy_len", mon_cyc, FW * CPB);
            check("end_txd", {31'b0, txd}, 32'd1);
            if (have_exp) exp_q.delete(0);
            mon_active = 1'b0;
            frames_done++;
            idle_cnt = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            tick();
        end
        check("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic send(input logic [7:0] d);
        data = d;
        ok   = 1'b1;
        exp_q.push_back(frame_of(d));
        tick();
        ok = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ok    = 1'b0;
        data  = 8'h00;
        #1;
        check("rst_async_txd", {31'b0, txd}, 32'd1);
        repeat (5) tick();
        reset = 1'b0;
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        repeat (50) tick();
        check("quiet_busy", {31'b0, busy}, 32'd0);
        check("quiet_frames", frames_done, 32'd0);

        // Single frame
        send(8'b1011_0011);
        check("accept_txd", {31'b0, txd}, 32'd0);
        check("accept_busy", {31'b0, busy}, 32'd1);
        wait_idle();
        repeat (5) tick();

        // Request during a frame is ignored
        send(8'h5A);
        repeat (9) tick();
        data = 8'hFF;
        ok   = 1'b1;
        tick();
        ok = 1'b0;
        wait_idle();
        repeat (30) tick();
        check("ignored_q", exp_q.size(), 32'd0);
        check("ignored_frames", frames_done, 32'd2);

        // Back-to-back with ok held high
        data = 8'h01;
        ok   = 1'b1;
        exp_q.push_back(frame_of(8'h01));
        tick();
        data = 8'h80;
        exp_q.push_back(frame_of(8'h80));
        wait_idle();
        tick();
        ok = 1'b0;
        check("b2b_busy2", {31'b0, busy}, 32'd1);
        wait_idle();
        repeat (3) tick();
        check("b2b_gap", last_gap, 32'd1);
        check("b2b_frames", frames_done, 32'd4);

        // Reset in the middle of a frame, then a clean frame
        send(8'h00);
        repeat (16) tick();
        check("pre_rst_txd", {31'b0, txd}, 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_txd", {31'b0, txd}, 32'd1);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        send(8'hC3);
        check("first_edge_accept", {31'b0, busy}, 32'd1);
        wait_idle();
        repeat (5) tick();

        check("final_q", exp_q.size(), 32'd0);
        check("final_frames", frames_done, 32'd5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
